// File: rtl/golden_nonce_queue_pkg.sv
// Shared constants and the leading-zero target test for the golden nonce queue.
package golden_nonce_queue_pkg;

    localparam int unsigned NONCE_OFFSET_DEFAULT = 132;
    localparam int unsigned DEPTH_DEFAULT        = 8;
    localparam int unsigned HASH_W               = 32;

    // True when the top min(zero_bits,32) bits of msw are all zero.
    function automatic logic msw_meets_target(input logic [HASH_W-1:0] msw,
                                              input logic [5:0]        zero_bits);
        logic [5:0]        zb;
        logic [HASH_W-1:0] mask;
        zb   = (zero_bits > 6'd32) ? 6'd32 : zero_bits;
        // Shifting by the full width yields zero, so zb=32 masks every bit.
        mask = ~({HASH_W{1'b1}} >> zb);
        return ((msw & mask) == '0);
    endfunction

endpackage

// File: rtl/golden_nonce_queue_fifo.sv
// First-word-fall-through FIFO; head word is presented combinationally, 0 when empty.
module sync_fifo_fwft
    import golden_nonce_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer advance; extra MSB distinguishes full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/golden_nonce_queue.sv
// Tests completed hashes against a leading-zero target, recovers the real nonce,
// and queues hits for host readout with hit/drop accounting.
module golden_nonce_queue
    import golden_nonce_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = DEPTH_DEFAULT,
    parameter int unsigned NONCE_OFFSET = NONCE_OFFSET_DEFAULT,
    localparam int unsigned LW          = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hash_valid,
    input  logic [31:0]   hash_msw,
    input  logic [31:0]   nonce_in,
    input  logic [5:0]    zero_bits,
    output logic          out_valid,
    output logic [31:0]   out_nonce,
    input  logic          out_ready,
    output logic [LW-1:0] level,
    output logic [31:0]   hit_count,
    output logic [15:0]   drop_count,
    output logic          overflow
);

    logic        hit_q, hit_d;
    logic [31:0] nonce_q, nonce_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        overflow_q, overflow_d;
    logic        fifo_full, fifo_empty;
    logic        push, pop, drop;

    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign push       = hit_q && (!fifo_full || pop);
    assign drop       = hit_q && fifo_full && !pop;
    assign hit_count  = hit_count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

    sync_fifo_fwft #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (nonce_q),
        .pop     (pop),
        .rdata   (out_nonce),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Next-state for the compare stage and the hit/drop bookkeeping.
    always_comb begin
        hit_d        = hash_valid && msw_meets_target(hash_msw, zero_bits);
        nonce_d      = nonce_in - 32'(NONCE_OFFSET);
        hit_count_d  = hit_count_q + {31'd0, hit_q};
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    // Stage-1 and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_q        <= 1'b0;
            nonce_q      <= '0;
            hit_count_q  <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            hit_q        <= hit_d;
            nonce_q      <= nonce_d;
            hit_count_q  <= hit_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_golden_nonce_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned OFS   = 132;

    logic        clk = 1'b0;
    logic        reset_n, hash_valid, out_ready, out_valid, overflow;
    logic [31:0] hash_msw, nonce_in, out_nonce, hit_count;
    logic [5:0]  zero_bits;
    logic [3:0]  level;
    logic [15:0] drop_count;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [31:0] mq[$];
    bit          m_hit;
    logic [31:0] m_nonce;
    logic [31:0] m_hits;
    int          m_drops;
    bit          m_ovf;

    golden_nonce_queue #(.DEPTH(DEPTH), .NONCE_OFFSET(OFS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hash_valid (hash_valid),
        .hash_msw   (hash_msw),
        .nonce_in   (nonce_in),
        .zero_bits  (zero_bits),
        .out_valid  (out_valid),
        .out_nonce  (out_nonce),
        .out_ready  (out_ready),
        .level      (level),
        .hit_count  (hit_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_hit(input logic [31:0] msw, input logic [5:0] zb);
        int          z;
        logic [63:0] w;
        z = (zb > 32) ? 32 : int'(zb);
        w = {32'd0, msw};
        return (w >> (32 - z)) == 64'd0;
    endfunction

    task automatic model_edge(input bit rst, input bit hv, input logic [31:0] msw,
                              input logic [31:0] nonce, input logic [5:0] zb, input bit rdy);
        bit pop;
        if (rst) begin
            mq.delete();
            m_hit = 0; m_nonce = 0; m_hits = 0; m_drops = 0; m_ovf = 0;
            return;
        end
        pop = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (m_hit) begin
            m_hits++;
            if (mq.size() < DEPTH) mq.push_back(m_nonce);
            else begin
                m_ovf = 1;
                if (m_drops < 16'hFFFF) m_drops++;
            end
        end
        m_hit   = hv && ref_hit(msw, zb);
        m_nonce = nonce - OFS;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, out_valid, mq.size() > 0);
        check({tag, ".nonce"}, out_nonce, (mq.size() > 0) ? mq[0] : 32'd0);
        check({tag, ".level"}, level, mq.size());
        check({tag, ".hits"},  hit_count, m_hits);
        check({tag, ".drops"}, drop_count, m_drops);
        check({tag, ".ovf"},   overflow, m_ovf);
    endtask

    task automatic step(input string tag, input bit rst, input bit hv, input logic [31:0] msw,
                        input logic [31:0] nonce, input logic [5:0] zb, input bit rdy);
        @(negedge clk);
        reset_n = ~rst; hash_valid = hv; hash_msw = msw;
        nonce_in = nonce; zero_bits = zb; out_ready = rdy;
        @(posedge clk);
        model_edge(rst, hv, msw, nonce, zb, rdy);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input bit rdy);
        step(tag, 0, 0, 32'hFFFF_FFFF, 32'h0, 6'd0, rdy);
    endtask

    task automatic try_hit(input string tag, input logic [31:0] msw, input logic [5:0] zb,
                           input int exp_hit);
        logic [31:0] base;
        base = m_hits;
        step(tag, 0, 1, msw, 32'h1234, zb, 1);
        idle(tag, 1);
        check({tag, ".delta"}, hit_count, base + exp_hit);
        idle(tag, 1);
    endtask

    initial begin
        reset_n = 0; hash_valid = 0; hash_msw = 0; nonce_in = 0; zero_bits = 0; out_ready = 0;
        step("rst", 1, 0, 0, 0, 0, 0);
        step("rst", 1, 0, 0, 0, 0, 0);
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);

        // 1: single hit, two-edge latency, offset subtract
        step("t1", 0, 1, 32'h0, 32'h100, 6'd32, 1);
        check("t1_lat", out_valid, 0);
        idle("t1", 1);
        check("t1_nonce", out_nonce, 32'h7C);
        check("t1_hits", hit_count, 1);
        idle("t1", 1);
        check("t1_level", level, 0);

        // 2: target boundaries
        try_hit("t2_zb31", 32'h1,        6'd31, 1);
        try_hit("t2_zb32", 32'h1,        6'd32, 0);
        try_hit("t2_16a",  32'h0000FFFF, 6'd16, 1);
        try_hit("t2_16b",  32'h00010000, 6'd16, 0);
        try_hit("t2_40a",  32'h1,        6'd40, 0);
        try_hit("t2_40b",  32'h0,        6'd40, 1);
        try_hit("t2_zb0",  32'hFFFFFFFF, 6'd0,  1);

        // 3: hash_valid low is ignored
        step("t3r", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("t3", 0, 0, 32'h0, 32'h55, 6'd0, 1);
        check("t3_hits", hit_count, 0);

        // 4: nonce wrap
        step("t4", 0, 1, 32'h0, 32'h10, 6'd8, 1);
        idle("t4", 0);
        check("t4_nonce", out_nonce, 32'hFFFFFF8C);
        idle("t4", 1);

        // 5: overflow with stalled consumer, then in-order drain
        step("t5r", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("t5", 0, 1, 32'h0, 32'h1000 + i, 6'd0, 0);
        idle("t5", 0);
        check("t5_level", level, 8);
        check("t5_drops", drop_count, 2);
        check("t5_ovf", overflow, 1);
        check("t5_hits", hit_count, 10);
        for (int i = 0; i < 8; i++) begin
            check("t5_order", out_nonce, 32'h1000 + i - OFS);
            idle("t5d", 1);
        end
        check("t5_empty", out_valid, 0);
        check("t5_ovf_sticky", overflow, 1);

        // 6: reset with pending hit and queued entries
        for (int i = 0; i < 4; i++) step("t6", 0, 1, 32'h0, 32'h2000 + i, 6'd4, 0);
        check("t6_pre_level", level, 3);
        step("t6r", 1, 0, 0, 0, 0, 0);
        check("t6_level", level, 0);
        check("t6_hits", hit_count, 0);
        for (int i = 0; i < 4; i++) idle("t6post", 1);
        check("t6_no_stale", out_valid, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          rst, hv, rdy;
            logic [31:0] msw;
            rst = ($urandom_range(0, 199) == 0);
            hv  = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 9) < 4);
            msw = $urandom;
            msw = msw >> $urandom_range(0, 32);
            step("rnd", rst, hv, msw, $urandom, 6'($urandom_range(0, 63)), rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
